// File: rtl/mcdf_arbiter_rr.sv
// mcdf_arbiter_rr: picks one requesting channel slave for the formatter.
// Lowest priority value wins; ties are broken round-robin (RR_EN=1) or by
// lowest channel index (RR_EN=0). Every output comes straight from a flop.
module mcdf_arbiter_rr #(
  parameter int NUM_CH = 4,
  parameter int PRIO_W = 2,
  parameter bit RR_EN  = 1'b1,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rstn,        // active-high synchronous reset (1 = reset)
  input  logic [NUM_CH*PRIO_W-1:0] slv_prios,
  input  logic [NUM_CH-1:0]        slv_reqs,
  input  logic                     f2a_id_req,
  output logic [NUM_CH-1:0]        a2s_acks,
  output logic [ID_W-1:0]          a2f_id,
  output logic                     a2f_val,
  output logic                     arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Channel count and last index at the widths the pointer arithmetic uses,
  // so the wrap works for any NUM_CH, not just powers of two.
  localparam logic [ID_W:0]     LP_NUM_CH   = (ID_W+1)'(NUM_CH);
  localparam logic [ID_W-1:0]   LP_LAST     = ID_W'(NUM_CH-1);
  localparam logic [PRIO_W-1:0] LP_PRIO_MAX = '1;

  // State and registered outputs
  state_t              r_state;
  state_t              w_state_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [NUM_CH-1:0]   r_acks;
  logic [ID_W-1:0]     r_id;
  logic                r_val;
  logic                r_busy;

  // Arbitration datapath
  logic [PRIO_W-1:0]   w_prio [NUM_CH];
  logic [PRIO_W-1:0]   w_min_prio;
  logic [NUM_CH-1:0]   w_cand;
  logic [NUM_CH-1:0]   w_onehot;
  logic                w_fix_found;
  logic [ID_W-1:0]     w_fix_win;
  logic                w_rr_found;
  logic [ID_W-1:0]     w_rr_win;
  logic [ID_W:0]       w_rr_idx;
  logic [ID_W-1:0]     w_win;
  logic [ID_W-1:0]     w_ptr_next;
  logic                w_any_req;
  logic                w_start;

  // Next values of the registered outputs
  logic [NUM_CH-1:0]   w_acks_next;
  logic [ID_W-1:0]     w_id_next;
  logic                w_val_next;
  logic                w_busy_next;

  // Per-channel priority slice and one-hot decode of the current winner
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_prio[gi]   = slv_prios[gi*PRIO_W +: PRIO_W];
      assign w_cand[gi]   = slv_reqs[gi] && (w_prio[gi] == w_min_prio);
      assign w_onehot[gi] = (w_win == ID_W'(gi));
    end
  endgenerate

  // Minimum priority value among the channels currently requesting
  always_comb begin
    w_min_prio = LP_PRIO_MAX;
    for (int i = 0; i < NUM_CH; i++) begin
      if (slv_reqs[i] && (w_prio[i] < w_min_prio)) begin
        w_min_prio = w_prio[i];
      end
    end
  end

  // Fixed tie-break: lowest-index candidate
  always_comb begin
    w_fix_found = 1'b0;
    w_fix_win   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_fix_found && w_cand[i]) begin
        w_fix_found = 1'b1;
        w_fix_win   = ID_W'(i);
      end
    end
  end

  // Round-robin tie-break: first candidate scanning upward from rr_ptr.
  // rr_ptr < NUM_CH and the offset < NUM_CH, so one subtraction wraps.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_win   = '0;
    w_rr_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_rr_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_rr_idx >= LP_NUM_CH) begin
        w_rr_idx = w_rr_idx - LP_NUM_CH;
      end
      if (!w_rr_found && w_cand[w_rr_idx[ID_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_win   = w_rr_idx[ID_W-1:0];
      end
    end
  end

  assign w_win      = RR_EN ? w_rr_win : w_fix_win;
  assign w_ptr_next = (w_win == LP_LAST) ? '0 : (w_win + 1'b1);
  assign w_any_req  = |slv_reqs;
  assign w_start    = (r_state == S_IDLE) && f2a_id_req && w_any_req;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; HOLD waits for the formatter to drop its level request
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start)     w_state_next = S_GRANT;
      S_GRANT:                  w_state_next = S_HOLD;
      S_HOLD:  if (!f2a_id_req) w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the output flops, driven from the next state
  always_comb begin
    w_acks_next = '0;
    w_id_next   = r_id;
    w_val_next  = 1'b0;
    w_busy_next = (w_state_next != S_IDLE);
    if (w_state_next == S_GRANT) begin
      w_acks_next = w_onehot;
      w_id_next   = w_win;
      w_val_next  = 1'b1;
    end
  end

  // Output registers; a2f_id keeps the last granted channel between grants
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_acks <= '0;
      r_id   <= '0;
      r_val  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_acks <= w_acks_next;
      r_id   <= w_id_next;
      r_val  <= w_val_next;
      r_busy <= w_busy_next;
    end
  end

  // Round-robin pointer: moves past the winner on every new grant, in both modes
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_rr_ptr <= '0;
    end else if (w_start) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

  assign a2s_acks = r_acks;
  assign a2f_id   = r_id;
  assign a2f_val  = r_val;
  assign arb_busy = r_busy;

endmodule

// File: tb/tb_mcdf_arbiter_rr.sv
// Bench for mcdf_arbiter_rr: three instances (4ch round-robin, 4ch fixed,
// 3ch round-robin) share one stimulus and are checked each cycle against
// a behavioural model, plus literal expectations for the directed scenarios.
module tb_mcdf_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [7:0] slv_prios;
  logic [3:0] slv_reqs;
  logic       f2a_id_req;

  logic [3:0] acks0, acks1;
  logic [2:0] acks2;
  logic [1:0] id0, id1, id2;
  logic       val0, val1, val2;
  logic       busy0, busy1, busy2;

  mcdf_arbiter_rr #(.NUM_CH(4), .PRIO_W(2), .RR_EN(1'b1)) u_dut_rr (
    .clk(clk), .rstn(rstn), .slv_prios(slv_prios), .slv_reqs(slv_reqs),
    .f2a_id_req(f2a_id_req), .a2s_acks(acks0), .a2f_id(id0), .a2f_val(val0),
    .arb_busy(busy0));

  mcdf_arbiter_rr #(.NUM_CH(4), .PRIO_W(2), .RR_EN(1'b0)) u_dut_fix (
    .clk(clk), .rstn(rstn), .slv_prios(slv_prios), .slv_reqs(slv_reqs),
    .f2a_id_req(f2a_id_req), .a2s_acks(acks1), .a2f_id(id1), .a2f_val(val1),
    .arb_busy(busy1));

  mcdf_arbiter_rr #(.NUM_CH(3), .PRIO_W(2), .RR_EN(1'b1)) u_dut_nc3 (
    .clk(clk), .rstn(rstn), .slv_prios(slv_prios[5:0]), .slv_reqs(slv_reqs[2:0]),
    .f2a_id_req(f2a_id_req), .a2s_acks(acks2), .a2f_id(id2), .a2f_val(val2),
    .arb_busy(busy2));

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase 0 = idle, 1 = granting, 2 = waiting for request drop
  int m_n  [3] = '{4, 4, 3};
  bit m_rr [3] = '{1'b1, 1'b0, 1'b1};
  int m_phase [3];
  int m_ptr   [3];
  int m_id    [3];
  bit chk_en = 1'b0;

  int q0[$];
  int q1[$];
  int q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner per the selection rules: minimum priority among requesters, then
  // either first found scanning up from the pointer or lowest index. -1 = none.
  function automatic int pick(input int k);
    int n;
    int minp;
    int c;
    logic [3:0] r;
    n = m_n[k];
    r = slv_reqs;
    if (n == 3) r[3] = 1'b0;
    minp = 4;
    for (int i = 0; i < n; i++) begin
      if (r[i] && (int'(slv_prios[2*i +: 2]) < minp)) minp = int'(slv_prios[2*i +: 2]);
    end
    for (int j = 0; j < n; j++) begin
      c = m_rr[k] ? ((m_ptr[k] + j) % n) : j;
      if (r[c] && (int'(slv_prios[2*c +: 2]) == minp)) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rstn) chk_en <= 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (rstn) begin
        m_phase[k] <= 0;
        m_ptr[k]   <= 0;
        m_id[k]    <= 0;
      end else begin
        case (m_phase[k])
          0: if (f2a_id_req && (pick(k) >= 0)) begin
               m_phase[k] <= 1;
               m_id[k]    <= pick(k);
               m_ptr[k]   <= (pick(k) + 1) % m_n[k];
             end
          1: m_phase[k] <= 2;
          default: if (!f2a_id_req) m_phase[k] <= 0;
        endcase
      end
    end
  end

  task automatic cmp(input int k, input logic [15:0] a, input logic [3:0] id,
                     input logic v, input logic b, input logic [3:0] p);
    logic [15:0] ea;
    ea = (m_phase[k] == 1) ? (16'd1 << m_id[k]) : 16'd0;
    check($sformatf("inst%0d_acks", k), 32'(a), 32'(ea));
    check($sformatf("inst%0d_id", k), 32'(id), 32'(m_id[k]));
    check($sformatf("inst%0d_val", k), 32'(v), 32'(m_phase[k] == 1));
    check($sformatf("inst%0d_busy", k), 32'(b), 32'(m_phase[k] != 0));
    check($sformatf("inst%0d_rr_ptr", k), 32'(p), 32'(m_ptr[k]));
    if (v === 1'b1) begin
      case (k)
        0: q0.push_back(int'(id));
        1: q1.push_back(int'(id));
        default: q2.push_back(int'(id));
      endcase
    end
  endtask

  // Single compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, {12'b0, acks0}, {2'b0, id0}, val0, busy0, {2'b0, u_dut_rr.r_rr_ptr});
      cmp(1, {12'b0, acks1}, {2'b0, id1}, val1, busy1, {2'b0, u_dut_fix.r_rr_ptr});
      cmp(2, {13'b0, acks2}, {2'b0, id2}, val2, busy2, {2'b0, u_dut_nc3.r_rr_ptr});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b1;
    step(n);
    rstn = 1'b0;
  endtask

  task automatic pulse();
    f2a_id_req = 1'b1;
    step(1);
    f2a_id_req = 1'b0;
    step(3);
  endtask

  task automatic clear_q();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  function automatic int qget(input int k, input int i);
    case (k)
      0: return (i < q0.size()) ? q0[i] : -1;
      1: return (i < q1.size()) ? q1[i] : -1;
      default: return (i < q2.size()) ? q2[i] : -1;
    endcase
  endfunction

  int exp_rr  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_nc3 [4] = '{0, 2, 0, 2};

  initial begin
    rstn       = 1'b1;
    f2a_id_req = 1'b0;
    slv_reqs   = 4'h0;
    slv_prios  = 8'h00;

    // Reset and idle: requests from the formatter but no slave requests
    do_reset(2);
    clear_q();
    f2a_id_req = 1'b1;
    step(10);
    check("idle_grants", 32'(q0.size()), 32'd0);
    check("idle_busy", 32'(busy0), 32'd0);
    f2a_id_req = 1'b0;
    step(1);

    // Strict priority: ch2 has priority 0
    slv_prios  = 8'h87;
    slv_reqs   = 4'hF;
    f2a_id_req = 1'b1;
    step(1);
    $display("strict: id=%0d acks=%b val=%0d", id0, acks0, val0);
    check("strict_id", 32'(id0), 32'd2);
    check("strict_acks", 32'(acks0), 32'h4);
    check("strict_val", 32'(val0), 32'd1);
    check("strict_fix_id", 32'(id1), 32'd2);
    f2a_id_req = 1'b0;
    step(3);

    // Round-robin fairness vs fixed tie-break
    do_reset(1);
    slv_prios = 8'h00;
    slv_reqs  = 4'hF;
    clear_q();
    repeat (8) pulse();
    check("rr_count", 32'(q0.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      $display("rr grant %0d: rr_id=%0d fix_id=%0d", i, qget(0, i), qget(1, i));
      check($sformatf("rr_seq%0d", i), 32'(qget(0, i)), 32'(exp_rr[i]));
      check($sformatf("fix_seq%0d", i), 32'(qget(1, i)), 32'd0);
    end

    // Level request held: one grant only, then a second after a drop
    clear_q();
    f2a_id_req = 1'b1;
    step(20);
    check("level_one_grant", 32'(q0.size()), 32'd1);
    f2a_id_req = 1'b0;
    step(1);
    f2a_id_req = 1'b1;
    step(3);
    check("level_second_grant", 32'(q0.size()), 32'd2);
    f2a_id_req = 1'b0;
    step(3);

    // Wrap with 3 channels, requests on ch0 and ch2
    do_reset(1);
    slv_prios = 8'h55;
    slv_reqs  = 4'b0101;
    clear_q();
    repeat (4) pulse();
    for (int i = 0; i < 4; i++) begin
      $display("wrap grant %0d: nc3_id=%0d rr_id=%0d", i, qget(2, i), qget(0, i));
      check($sformatf("nc3_seq%0d", i), 32'(qget(2, i)), 32'(exp_nc3[i]));
      check($sformatf("wrap4_seq%0d", i), 32'(qget(0, i)), 32'(exp_nc3[i]));
    end

    // Reset in the GRANT cycle
    do_reset(1);
    slv_prios = 8'h00;
    slv_reqs  = 4'hF;
    pulse();
    f2a_id_req = 1'b1;
    step(1);
    check("midgrant_val", 32'(val0), 32'd1);
    check("midgrant_id", 32'(id0), 32'd1);
    rstn       = 1'b1;
    f2a_id_req = 1'b0;
    step(1);
    check("midgrant_ack_clear", 32'(acks0), 32'd0);
    check("midgrant_val_clear", 32'(val0), 32'd0);
    check("midgrant_busy_clear", 32'(busy0), 32'd0);
    rstn = 1'b0;
    step(2);
    clear_q();
    pulse();
    $display("post-reset grant: id=%0d", qget(0, 0));
    check("postreset_id", 32'(qget(0, 0)), 32'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      slv_prios  = 8'($urandom);
      slv_reqs   = 4'($urandom);
      f2a_id_req = ($urandom_range(0, 3) != 0);
      rstn       = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rstn = 1'b0;
    f2a_id_req = 1'b0;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
